// File: rtl/ysyx_23060184_pkg.sv
// ysyx_23060184_pkg
//   Definitions shared by the IFU: the FSM state encoding, the default
//   reset PC and the AXI read-response OKAY code.
package ysyx_23060184_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,   // one cycle after reset release
        S_AR   = 3'd1,   // address phase
        S_R    = 3'd2,   // data phase
        S_OUT  = 3'd3,   // instruction presented to decode
        S_WAIT = 3'd4    // waiting for the next PC
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [1:0]  RRESP_OKAY   = 2'b00;

endpackage

// File: rtl/ysyx_23060184_ifu_if.sv
// ysyx_23060184_ifu_if
//   Instruction-memory read bus (AXI-lite style AR and R channels).
//   master : IFU side   (drives arvalid/araddr/rready)
//   slave  : memory side (drives arready/rvalid/rdata/rresp)
interface ysyx_23060184_ifu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_arvalid;
    logic [DATA_WIDTH-1:0] imem_araddr;
    logic                  imem_arready;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic [1:0]            imem_rresp;
    logic                  imem_rready;

    modport master (
        output imem_arvalid, imem_araddr, imem_rready,
        input  imem_arready, imem_rvalid, imem_rdata, imem_rresp
    );

    modport slave (
        input  imem_arvalid, imem_araddr, imem_rready,
        output imem_arready, imem_rvalid, imem_rdata, imem_rresp
    );
endinterface

// File: rtl/ysyx_23060184_ifu.sv
// ysyx_23060184_ifu
//   Instruction fetch unit: holds the PC, fetches one instruction per PC
//   over the imem bus, presents it to decode and waits for the next PC.
//
//   Ports
//     clk, resetn          : clock, asynchronous active-low reset
//     NPC, npc_valid       : next PC from the NPC stage and its commit strobe
//     imem                 : instruction-memory read bus (master modport)
//     PC, Inst, inst_valid : presented instruction and its address
//     inst_ready           : decode accepts Inst
//     fetch_err            : fault attached to the presented Inst
//
//   Optional feature: define YSYX_23060184_IFU_ALIGN_CHK_EN to turn a
//   misaligned PC into a fetch fault without touching the bus.
module ysyx_23060184_ifu
    import ysyx_23060184_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] NPC,
    input  logic                  npc_valid,
    ysyx_23060184_ifu_if.master   imem,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] Inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  fetch_err
);

    ifu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  err_q, err_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: state_d = S_AR;
            S_AR: begin
                if (imem.imem_arready) state_d = S_R;
            end
            S_R: begin
                if (imem.imem_rvalid) begin
                    inst_d  = imem.imem_rdata;
                    err_d   = (imem.imem_rresp != RRESP_OKAY);
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                // A PC committed in the same cycle as the handshake skips S_WAIT.
                if (inst_ready) begin
                    if (npc_valid) begin
                        pc_d    = NPC;
                        state_d = S_AR;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (npc_valid) begin
                    pc_d    = NPC;
                    state_d = S_AR;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef YSYX_23060184_IFU_ALIGN_CHK_EN
        // Screen the PC as the FSM enters S_AR: a misaligned address never
        // reaches the bus and is reported straight away as a faulting fetch.
        if (state_d == S_AR && state_q != S_AR && pc_d[1:0] != 2'b00) begin
            state_d = S_OUT;
            inst_d  = '0;
            err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs are decoded from state alone.
    assign imem.imem_arvalid = (state_q == S_AR);
    assign imem.imem_rready  = (state_q == S_R);
    assign imem.imem_araddr  = pc_q;
    assign inst_valid        = (state_q == S_OUT);
    assign PC                = pc_q;
    assign Inst              = inst_q;
    assign fetch_err         = err_q;

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// tb_ysyx_23060184_ifu
//   Directed bench for the IFU: reset state, zero-wait and stalled fetches,
//   decode back-pressure, error response, ignored strobes, PC wrap,
//   misaligned PC and reset in the middle of a transaction.
module tb_ysyx_23060184_ifu;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] npc;
    logic        npc_valid;
    logic [31:0] pc, inst;
    logic        inst_valid, inst_ready, fetch_err;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_23060184_ifu_if #(.DATA_WIDTH(32)) imem ();

    ysyx_23060184_ifu #(.DATA_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .NPC        (npc),
        .npc_valid  (npc_valid),
        .imem       (imem),
        .PC         (pc),
        .Inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic ar, input logic rv, input logic [31:0] d, input logic [1:0] rs);
        imem.imem_arready = ar;
        imem.imem_rvalid  = rv;
        imem.imem_rdata   = d;
        imem.imem_rresp   = rs;
    endtask

    initial begin
        resetn = 1'b0; npc = '0; npc_valid = 1'b0; inst_ready = 1'b0;
        mem(1'b0, 1'b0, 32'h0, 2'b00);
        step(); step();

        // reset state
        check("rst_arvalid", {31'b0, imem.imem_arvalid}, 32'd0);
        check("rst_rready",  {31'b0, imem.imem_rready},  32'd0);
        check("rst_ivalid",  {31'b0, inst_valid},        32'd0);
        check("rst_pc",      pc,                         32'h8000_0000);
        check("rst_inst",    inst,                       32'h0);
        check("rst_err",     {31'b0, fetch_err},         32'd0);

        // zero-wait first fetch from the reset PC, no npc_valid needed
        resetn = 1'b1;
        mem(1'b1, 1'b1, 32'h0000_0413, 2'b00);
        #1 check("idle_arvalid", {31'b0, imem.imem_arvalid}, 32'd0);
        step();
        check("c1_arvalid", {31'b0, imem.imem_arvalid}, 32'd1);
        check("c1_araddr",  imem.imem_araddr,           32'h8000_0000);
        step();
        check("c2_rready",  {31'b0, imem.imem_rready},  32'd1);
        check("c2_arvalid", {31'b0, imem.imem_arvalid}, 32'd0);
        step();
        check("c3_ivalid", {31'b0, inst_valid}, 32'd1);
        check("c3_pc",     pc,                  32'h8000_0000);
        check("c3_inst",   inst,                32'h0000_0413);
        check("c3_err",    {31'b0, fetch_err},  32'd0);
        mem(1'b0, 1'b0, 32'h0, 2'b00);

        // decode back-pressure for 4 cycles; a lone npc_valid is ignored
        for (int i = 0; i < 4; i++) begin
            npc_valid = (i == 1);
            npc       = 32'hdead_beef;
            step();
            check("hold_ivalid", {31'b0, inst_valid}, 32'd1);
            check("hold_inst",   inst,                32'h0000_0413);
            check("hold_pc",     pc,                  32'h8000_0000);
        end
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0010;
        step();
        inst_ready = 1'b0; npc_valid = 1'b0;
        check("npc_arvalid", {31'b0, imem.imem_arvalid}, 32'd1);
        check("npc_araddr",  imem.imem_araddr,           32'h8000_0010);
        check("npc_ivalid",  {31'b0, inst_valid},        32'd0);

        // arready delayed: address held stable
        for (int i = 0; i < 3; i++) begin
            step();
            check("arw_arvalid", {31'b0, imem.imem_arvalid}, 32'd1);
            check("arw_araddr",  imem.imem_araddr,           32'h8000_0010);
        end
        mem(1'b1, 1'b0, 32'h0, 2'b00);
        step();
        mem(1'b0, 1'b0, 32'h0, 2'b00);
        // rvalid delayed 2 cycles, then an error response
        for (int i = 0; i < 2; i++) begin
            check("rw_rready", {31'b0, imem.imem_rready}, 32'd1);
            check("rw_ivalid", {31'b0, inst_valid},       32'd0);
            step();
        end
        mem(1'b0, 1'b1, 32'h0010_0093, 2'b10);
        step();
        mem(1'b0, 1'b0, 32'h0, 2'b00);
        check("err_ivalid", {31'b0, inst_valid}, 32'd1);
        check("err_inst",   inst,                32'h0010_0093);
        check("err_flag",   {31'b0, fetch_err},  32'd1);
        check("err_pc",     pc,                  32'h8000_0010);

        // accept without a PC -> S_WAIT; stray rvalid there is ignored
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("wait_ivalid",  {31'b0, inst_valid},        32'd0);
        check("wait_arvalid", {31'b0, imem.imem_arvalid}, 32'd0);
        mem(1'b0, 1'b1, 32'hffff_ffff, 2'b00);
        step();
        mem(1'b0, 1'b0, 32'h0, 2'b00);
        check("stray_inst",   inst,                       32'h0010_0093);
        check("stray_ivalid", {31'b0, inst_valid},        32'd0);

        // top-of-space PC, error flag clears on an OKAY fetch
        npc_valid = 1'b1; npc = 32'hffff_fffc;
        step();
        npc_valid = 1'b0;
        check("top_araddr", imem.imem_araddr, 32'hffff_fffc);
        mem(1'b1, 1'b1, 32'h0000_0013, 2'b00);
        step(); step();
        mem(1'b0, 1'b0, 32'h0, 2'b00);
        check("top_ivalid", {31'b0, inst_valid}, 32'd1);
        check("top_pc",     pc,                  32'hffff_fffc);
        check("top_inst",   inst,                32'h0000_0013);
        check("top_errclr", {31'b0, fetch_err},  32'd0);

        // misaligned PC
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0006;
        step();
        inst_ready = 1'b0; npc_valid = 1'b0;
`ifdef YSYX_23060184_IFU_ALIGN_CHK_EN
        check("mis_arvalid", {31'b0, imem.imem_arvalid}, 32'd0);
        check("mis_ivalid",  {31'b0, inst_valid},        32'd1);
        check("mis_err",     {31'b0, fetch_err},         32'd1);
        check("mis_inst",    inst,                       32'h0);
`else
        check("mis_arvalid", {31'b0, imem.imem_arvalid}, 32'd1);
        check("mis_araddr",  imem.imem_araddr,           32'h8000_0006);
        mem(1'b1, 1'b1, 32'h0000_0093, 2'b00);
        step(); step();
        mem(1'b0, 1'b0, 32'h0, 2'b00);
        check("mis_ivalid", {31'b0, inst_valid}, 32'd1);
        check("mis_err",    {31'b0, fetch_err},  32'd0);
`endif

        // reset asserted mid-transaction in S_R
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0020;
        mem(1'b1, 1'b0, 32'h0, 2'b00);
        step();
        inst_ready = 1'b0; npc_valid = 1'b0;
        step();
        mem(1'b0, 1'b0, 32'h0, 2'b00);
        check("sr_rready", {31'b0, imem.imem_rready}, 32'd1);
        resetn = 1'b0;
        #1;
        check("arst_rready", {31'b0, imem.imem_rready}, 32'd0);
        check("arst_pc",     pc,                        32'h8000_0000);
        check("arst_inst",   inst,                      32'h0);
        check("arst_err",    {31'b0, fetch_err},        32'd0);
        step();
        resetn = 1'b1;
        mem(1'b1, 1'b1, 32'h0000_0413, 2'b00);
        step();
        check("refetch_arvalid", {31'b0, imem.imem_arvalid}, 32'd1);
        check("refetch_araddr",  imem.imem_araddr,           32'h8000_0000);
        step(); step();
        check("refetch_inst", inst, 32'h0000_0413);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
